i8088_bus_master: RTL and testbench

I8088_BUS_MASTER -- requirements
Module: i8088_bus_master

---
 rtl/i8088_bus_master_if.sv | 37 +++
 rtl/i8088_bus_master.sv | 147 ++++++++++++++
 tb/tb_i8088_bus_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i8088_bus_master_if.sv
// Host handshake and 8088-style bus control signals for i8088_bus_master.
// The tristate Data bus stays a discrete inout port on the master itself.
interface i8088_bus_master_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 8
) ();
   // Host side
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic                  req_io;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   // Bus side
   logic                  ALE;
   logic                  RD;
   logic                  WR;
   logic                  IOM;
   logic                  READY;
   logic [ADDR_WIDTH-1:0] Address;

   modport master (
      input  req_valid, req_write, req_io, req_addr, req_wdata, READY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output ALE, RD, WR, IOM, Address
   );

   modport slave (
      output req_valid, req_write, req_io, req_addr, req_wdata, READY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  ALE, RD, WR, IOM, Address
   );
endinterface

// File: rtl/i8088_bus_master.sv
// 8088-style T1..T4 bus master with READY wait states and a demultiplexed address bus.
// Define I8088_BUS_MASTER_TIMEOUT_EN to abort cycles that wait TIMEOUT_CYCLES TW clocks.
module i8088_bus_master #(
   parameter int ADDR_WIDTH     = 20,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   i8088_bus_master_if.master    bus,
   inout  wire  [DATA_WIDTH-1:0] Data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_TW,
      S_T4
   } state_t;

   state_t                state;
   state_t                state_next;

   logic                  write_q;
   logic                  io_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  req_ready;
   logic                  accept;
   logic                  ale;
   logic                  rd_n;
   logic                  wr_n;
   logic                  data_oe;
   logic                  in_wait;
   logic                  bus_done;
   logic                  timeout_hit;

   assign in_wait  = (state == S_T3) || (state == S_TW);
   assign bus_done = in_wait && bus.READY;
   assign accept   = bus.req_valid && req_ready;

`ifdef I8088_BUS_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // wait_cnt holds the number of TW clocks already completed, so the
   // TIMEOUT_CYCLES-th TW clock is the one seeing TIMEOUT_CYCLES-1.
   assign timeout_hit = (state == S_TW) && !bus.READY &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK) begin
      if (RESET || state == S_T1) begin
         wait_cnt <= '0;
      end else if (state == S_TW) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      ale        = 1'b0;
      rd_n       = 1'b1;
      wr_n       = 1'b1;
      data_oe    = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) state_next = S_T1;
         end
         S_T1: begin
            ale        = 1'b1;
            state_next = S_T2;
         end
         S_T2: begin
            rd_n       = write_q;
            wr_n       = !write_q;
            data_oe    = write_q;
            state_next = S_T3;
         end
         S_T3, S_TW: begin
            rd_n       = write_q;
            wr_n       = !write_q;
            data_oe    = write_q;
            state_next = (bus.READY || timeout_hit) ? S_T4 : S_TW;
         end
         S_T4: begin
            req_ready  = 1'b1;
            data_oe    = write_q;
            state_next = bus.req_valid ? S_T1 : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         write_q <= 1'b0;
         io_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            write_q <= bus.req_write;
            io_q    <= bus.req_io;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (bus_done && !write_q) rdata_q <= Data;
         if (timeout_hit)          rdata_q <= '0;
         if (in_wait)              err_q   <= timeout_hit;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state == S_T4);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = (state == S_T4) && err_q;

   assign bus.ALE     = ale;
   assign bus.RD      = rd_n;
   assign bus.WR      = wr_n;
   assign bus.IOM     = io_q;
   assign bus.Address = addr_q;

   assign Data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_i8088_bus_master.sv
// Randomized bench for i8088_bus_master: responder model on the bus, scoreboard on rsp_*.
// Undriven Data is pulled up, so a released bus reads as all ones.
module tb_i8088_bus_master;

   localparam int AW  = 20;
   localparam int DW  = 8;
   localparam int TMO = 16;

   typedef struct {
      bit          wr;
      bit          io;
      logic [19:0] addr;
      logic [7:0]  wdata;
      int          waits;
      int          acc;
      logic [7:0]  rdata;
      bit          err;
   } tx_t;

   logic clk;
   logic rst;
   wire  [DW-1:0] Data;

   i8088_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   i8088_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus),
      .Data  (Data)
   );

   pullup pu (Data);

   logic          resp_oe;
   logic [DW-1:0] resp_data;
   assign Data = resp_oe ? resp_data : {DW{1'bz}};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   tx_t        exp_q[$];
   tx_t        bus_q[$];
   int         wait_q[$];
   logic [7:0] ref_mem[int];
   logic [7:0] bus_mem[int];
   int         wkeys[$];
   logic [7:0] last_rdata = '0;
   int         last_acc   = 0;

   int         j     = 100;
   int         n_cur = 0;
   int         r_key = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int key(input logic io, input logic [19:0] a);
      return int'({11'd0, io, a});
   endfunction

   function automatic logic [7:0] dflt(input int k);
      return 8'((k * 37) ^ 8'h5A);
   endfunction

   function automatic logic [7:0] peek_bus(input int k);
      return bus_mem.exists(k) ? bus_mem[k] : dflt(k);
   endfunction

   function automatic logic [7:0] peek_ref(input int k);
      return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
   endfunction

   // Responder: READY stays low for the first n samples from T3 onward.
   always @(posedge clk) begin
      #1;
      if (bus.ALE) begin
         j     = 0;
         n_cur = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
         r_key = key(bus.IOM, bus.Address);
      end else begin
         j++;
      end
      bus.READY = !(j >= 2 && (j - 2) < n_cur);
      resp_oe   = !bus.RD;
      resp_data = peek_bus(r_key);
   end

   always @(negedge clk) begin
      if (!bus.WR && bus.READY && j >= 2) bus_mem[r_key] = Data;
   end

   // Bus protocol checker: phase k counts clocks since T1 of the front transaction.
   always @(negedge clk) begin
      tx_t t;
      int  k;
      int  last;
      bit  strobe;
      if (!rst) begin
         if (bus_q.size() > 0 && cyc >= bus_q[0].acc) begin
            t      = bus_q[0];
            k      = cyc - t.acc;
            last   = 3 + t.waits;
            strobe = (k >= 1) && (k < last);
            check("ale", bus.ALE, k == 0);
            check("address", bus.Address, t.addr);
            check("iom", bus.IOM, t.io);
            check("rd", bus.RD, !(strobe && !t.wr));
            check("wr", bus.WR, !(strobe && t.wr));
            check("req_ready_busy", bus.req_ready, k == last);
            if (t.wr && k >= 1)  check("data_drive", Data, t.wdata);
            else if (!strobe)    check("data_release", Data, 8'hFF);
            if (k >= last) void'(bus_q.pop_front());
         end else begin
            check("idle_ale", bus.ALE, 0);
            check("idle_rd", bus.RD, 1);
            check("idle_wr", bus.WR, 1);
            check("idle_data", Data, 8'hFF);
            check("idle_req_ready", bus.req_ready, 1);
         end
      end
   end

   // Scoreboard: every rsp_valid pulse pops one expected response.
   always @(negedge clk) begin
      tx_t e;
      if (!rst && bus.rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", bus.rsp_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", bus.rsp_err, e.err);
            check("rsp_latency", cyc - e.acc, 3 + e.waits);
         end
      end
   end

   task automatic issue(input bit wr, input bit io, input logic [19:0] a,
                        input logic [7:0] d, input int n, input bit expect_rsp);
      tx_t t;
      int  budget;
      int  k;
      t.wr = wr; t.io = io; t.addr = a; t.wdata = d;
      t.waits = n; t.err = 1'b0;
`ifdef I8088_BUS_MASTER_TIMEOUT_EN
      if (n > TMO) begin
         t.waits = TMO;
         t.err   = 1'b1;
      end
`endif
      k = key(io, a);
      wait_q.push_back(n);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_io    = io;
      bus.req_addr  = a;
      bus.req_wdata = d;
      budget = 0;
      while (!bus.req_ready && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!bus.req_ready) begin
         check("req_accept_timeout", bus.req_ready, 1);
         bus.req_valid = 1'b0;
         return;
      end
      t.acc    = cyc + 1;
      last_acc = t.acc;
      if (expect_rsp) begin
         if (t.err)     t.rdata = '0;
         else if (wr)   t.rdata = last_rdata;
         else           t.rdata = peek_ref(k);
         last_rdata = t.rdata;
         if (wr && !t.err) begin
            ref_mem[k] = d;
            wkeys.push_back(k);
         end
         exp_q.push_back(t);
      end
      bus_q.push_back(t);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 0;
      while ((exp_q.size() > 0 || bus_q.size() > 0) && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("pending_rsp", exp_q.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ale"},       bus.ALE, 0);
      check({tag, "_rd"},        bus.RD, 1);
      check({tag, "_wr"},        bus.WR, 1);
      check({tag, "_iom"},       bus.IOM, 0);
      check({tag, "_address"},   bus.Address, 0);
      check({tag, "_data"},      Data, 8'hFF);
      check({tag, "_req_ready"}, bus.req_ready, 1);
      check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      check({tag, "_rsp_err"},   bus.rsp_err, 0);
      check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a1;
      int a2;
      rst           = 1'b1;
      resp_oe       = 1'b0;
      resp_data     = '0;
      bus.READY     = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_io    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      // Directed: memory read, I/O write, wait-state read.
      bus_mem[key(1'b0, 20'h12345)] = 8'hA5;
      ref_mem[key(1'b0, 20'h12345)] = 8'hA5;
      issue(1'b0, 1'b0, 20'h12345, 8'h00, 0, 1'b1);
      drain();
      issue(1'b1, 1'b1, 20'h00080, 8'h3C, 0, 1'b1);
      drain();
      check("io_mem_80", peek_bus(key(1'b1, 20'h00080)), 8'h3C);
      issue(1'b0, 1'b0, 20'h12345, 8'h00, 3, 1'b1);
      drain();

      // Back-to-back write then read of the same location.
      issue(1'b1, 1'b0, 20'h00010, 8'h11, 0, 1'b1);
      a1 = last_acc;
      issue(1'b0, 1'b0, 20'h00010, 8'h00, 0, 1'b1);
      a2 = last_acc;
      check("b2b_gap", a2 - a1, 4);
      drain();

      // Reset during T3 of a write held by wait states.
      issue(1'b1, 1'b0, 20'h00020, 8'h77, 3, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      bus_q.delete();
      last_rdata = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset("midreset");
      repeat (6) @(negedge clk);
      check("aborted_write_mem", peek_bus(key(1'b0, 20'h00020)), dflt(key(1'b0, 20'h00020)));

      // Random traffic with wait states and random gaps.
      for (int i = 0; i < 40; i++) begin
         logic        wr;
         logic        io;
         logic [19:0] a;
         wr = 1'($urandom_range(0, 1));
         io = 1'($urandom_range(0, 1));
         a  = 20'($urandom_range(0, 15));
         issue(wr, io, a, 8'($urandom_range(0, 254)), int'($urandom_range(0, 4)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

`ifdef I8088_BUS_MASTER_TIMEOUT_EN
      issue(1'b0, 1'b0, 20'h00300, 8'h00, 1000, 1'b1);
      drain();
      issue(1'b0, 1'b0, 20'h12345, 8'h00, 1, 1'b1);
      drain();
`endif

      foreach (wkeys[i]) check("mem_contents", peek_bus(wkeys[i]), peek_ref(wkeys[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
